// File: rtl/conv_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and its pixel source / window consumer.
// master = sequencer side, slave = environment side.
interface conv_frame_sequencer_if #(
    parameter int AW = 1
);
    logic          start;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic          buf_clk_en;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_x;
    logic [AW-1:0] out_y;
    logic          busy;
    logic          frame_done;

    modport master (
        input  start, abort, in_valid, out_ready,
        output in_ready, buf_clk_en, out_valid, out_x, out_y, busy, frame_done
    );

    modport slave (
        output start, abort, in_valid, out_ready,
        input  in_ready, buf_clk_en, out_valid, out_x, out_y, busy, frame_done
    );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Raster-scans one square frame and flags each complete filter window; window valid 1 cycle after its last pixel.
// Backpressure: a held, unconsumed window stalls pixel intake (in_ready low) until out_ready.
module conv_frame_sequencer #(
    parameter int FILTER_SIZE = -1,
    parameter int IMAGE_SIZE  = -1
) (
    input  logic                    clk,
    input  logic                    rst,
    conv_frame_sequencer_if.master  bus
);
    localparam int AW = (IMAGE_SIZE >= 2) ? $clog2(IMAGE_SIZE) : 1;
    localparam logic [AW-1:0] F_M1 = AW'(FILTER_SIZE - 1);
    localparam logic [AW-1:0] LAST = AW'(IMAGE_SIZE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (IMAGE_SIZE < 2 || FILTER_SIZE < 1 || FILTER_SIZE > IMAGE_SIZE) begin : g_bad_param
        $error("conv_frame_sequencer: illegal FILTER_SIZE/IMAGE_SIZE");
    end

    logic [1:0]    state;
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic          out_valid_q;
    logic [AW-1:0] out_x_q;
    logic [AW-1:0] out_y_q;

    logic in_ready;
    logic accept;
    logic in_win;
    logic win;
    logic x_wrap;
    logic last_px;
    logic abort_hit;

    // With a 1-pixel filter every position is a window origin.
    if (FILTER_SIZE == 1) begin : g_f1
        assign in_win = 1'b1;
    end else begin : g_fn
        assign in_win = (x >= F_M1) && (y >= F_M1);
    end

    always_comb begin
        in_ready  = (state == S_RUN) && (bus.out_ready || !out_valid_q);
        accept    = bus.in_valid && in_ready;
        x_wrap    = (x == LAST);
        win       = accept && in_win;
        last_px   = accept && x_wrap && (y == LAST);
        abort_hit = bus.abort && ((state == S_RUN) || (state == S_DRAIN));
    end

    assign bus.in_ready   = in_ready;
    assign bus.buf_clk_en = accept;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.frame_done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else if (abort_hit) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_RUN;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                S_RUN: begin
                    if (last_px) begin
                        state <= S_DRAIN;
                        x     <= '0;
                        y     <= '0;
                    end else if (accept && x_wrap) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else if (accept) begin
                        x <= x + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!out_valid_q || bus.out_ready) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase

            // A freshly completed window replaces the one being consumed, so no bubble.
            if (win) begin
                out_valid_q <= 1'b1;
                out_x_q     <= x - F_M1;
                out_y_q     <= y - F_M1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: three configurations (4/3, 8/3, 2/1) behind one selector.
module tb_conv_frame_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic start, abort, in_valid, out_ready;
    int   sel;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    conv_frame_sequencer_if #(.AW(2)) bus_a ();
    conv_frame_sequencer_if #(.AW(3)) bus_b ();
    conv_frame_sequencer_if #(.AW(1)) bus_c ();

    assign bus_a.start     = start && (sel == 0);
    assign bus_a.abort     = abort && (sel == 0);
    assign bus_a.in_valid  = in_valid && (sel == 0);
    assign bus_a.out_ready = out_ready;
    assign bus_b.start     = start && (sel == 1);
    assign bus_b.abort     = abort && (sel == 1);
    assign bus_b.in_valid  = in_valid && (sel == 1);
    assign bus_b.out_ready = out_ready;
    assign bus_c.start     = start && (sel == 2);
    assign bus_c.abort     = abort && (sel == 2);
    assign bus_c.in_valid  = in_valid && (sel == 2);
    assign bus_c.out_ready = out_ready;

    conv_frame_sequencer #(.FILTER_SIZE(3), .IMAGE_SIZE(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
    conv_frame_sequencer #(.FILTER_SIZE(3), .IMAGE_SIZE(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));
    conv_frame_sequencer #(.FILTER_SIZE(1), .IMAGE_SIZE(2)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.master));

    logic m_ir, m_be, m_ov, m_busy, m_fd;
    int   m_ox, m_oy;

    always_comb begin
        m_ir = 1'b0; m_be = 1'b0; m_ov = 1'b0; m_busy = 1'b0; m_fd = 1'b0; m_ox = 0; m_oy = 0;
        case (sel)
            0: begin
                m_ir = bus_a.in_ready; m_be = bus_a.buf_clk_en; m_ov = bus_a.out_valid;
                m_busy = bus_a.busy; m_fd = bus_a.frame_done;
                m_ox = int'(bus_a.out_x); m_oy = int'(bus_a.out_y);
            end
            1: begin
                m_ir = bus_b.in_ready; m_be = bus_b.buf_clk_en; m_ov = bus_b.out_valid;
                m_busy = bus_b.busy; m_fd = bus_b.frame_done;
                m_ox = int'(bus_b.out_x); m_oy = int'(bus_b.out_y);
            end
            default: begin
                m_ir = bus_c.in_ready; m_be = bus_c.buf_clk_en; m_ov = bus_c.out_valid;
                m_busy = bus_c.busy; m_fd = bus_c.frame_done;
                m_ox = int'(bus_c.out_x); m_oy = int'(bus_c.out_y);
            end
        endcase
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always valid/ready; 1: random valid/ready; 2: stall the first window 5 cycles.
    task automatic run_frame(input int is, input int fs, input int mode, input int sa);
        int  n = is - fs + 1;
        int  px = 0, k = 0, fd = 0, stalls = 0;
        int  pex = 0, pey = 0, hx = 0, hy = 0, exp_ir, px_x, px_y;
        bit  pend = 0, hold = 0, done = 0;
        start = 1; abort = sa[0]; in_valid = 0; out_ready = 1;
        step();
        start = 0; abort = 0;
        chk("start_busy", m_busy, 1);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (pend) begin
                chk("lat_vld", m_ov, 1); chk("lat_x", m_ox, pex); chk("lat_y", m_oy, pey);
                pend = 0;
            end else if (hold) begin
                chk("hold_vld", m_ov, 1); chk("hold_x", m_ox, hx); chk("hold_y", m_oy, hy);
            end
            if (m_fd) begin fd++; done = 1; end
            if (mode == 1) begin
                in_valid  = ($urandom_range(0, 1) == 1);
                out_ready = ($urandom_range(0, 3) != 0);
            end else if (mode == 2) begin
                in_valid  = 1;
                out_ready = !(m_ov && stalls < 5);
                if (!out_ready) stalls++;
            end else begin
                in_valid = 1; out_ready = 1;
            end
            #1;
            exp_ir = (px < is * is && (out_ready || !m_ov)) ? 1 : 0;
            chk("in_ready", m_ir, exp_ir);
            chk("buf_clk_en", m_be, exp_ir & int'(in_valid));
            if (m_ov && out_ready) begin
                chk("win_x", m_ox, k % n); chk("win_y", m_oy, k / n);
                k++;
            end
            hold = m_ov && !out_ready; hx = m_ox; hy = m_oy;
            if (m_be) begin
                px_x = px % is; px_y = px / is;
                if (px_x >= fs - 1 && px_y >= fs - 1) begin
                    pend = 1; pex = px_x - fs + 1; pey = px_y - fs + 1;
                end
                px++;
            end
            step();
        end
        chk("frame_px", px, is * is);
        chk("frame_win", k, n * n);
        chk("frame_done_cnt", fd, 1);
        chk("fd_pulse", m_fd, 0);
        chk("idle_busy", m_busy, 0);
        if (mode == 2) chk("stall_cycles", stalls, 5);
        in_valid = 0; out_ready = 1;
    endtask

    task automatic abort_at(input int n);
        start = 1; in_valid = 1; out_ready = 1;
        step();
        start = 0;
        for (int i = 0; i < n; i++) step();
        chk("pre_abort_vld", m_ov, (n >= 11) ? 1 : 0);
        abort = 1;
        step();
        abort = 0;
        chk("abort_busy", m_busy, 0);
        chk("abort_vld", m_ov, 0);
        chk("abort_be", m_be, 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_fd", m_fd, 0);
            step();
        end
        in_valid = 0;
    endtask

    task automatic reset_mid();
        start = 1; in_valid = 1; out_ready = 1;
        step();
        start = 0;
        for (int i = 0; i < 12; i++) step();
        chk("pre_rst_x", m_ox, 1);
        #2;
        rst = 1;
        #1;
        chk("rst_busy", m_busy, 0); chk("rst_vld", m_ov, 0); chk("rst_ir", m_ir, 0);
        chk("rst_be", m_be, 0);     chk("rst_x", m_ox, 0);   chk("rst_fd", m_fd, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_busy", m_busy, 0);
            chk("post_rst_be", m_be, 0);
        end
        in_valid = 0;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; in_valid = 0; out_ready = 0; sel = 0;
        #12;
        chk("reset_busy", m_busy, 0); chk("reset_vld", m_ov, 0); chk("reset_ir", m_ir, 0);
        chk("reset_be", m_be, 0);     chk("reset_fd", m_fd, 0);  chk("reset_x", m_ox, 0);
        @(negedge clk);
        rst = 0;
        step();

        run_frame(4, 3, 0, 0);
        run_frame(4, 3, 2, 0);
        abort_at(7);
        run_frame(4, 3, 0, 1);
        abort_at(11);
        reset_mid();
        run_frame(4, 3, 0, 0);

        sel = 1;
        step();
        for (int f = 0; f < 3; f++) run_frame(8, 3, 1, 0);

        sel = 2;
        step();
        run_frame(2, 1, 0, 0);
        run_frame(2, 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_frame_sequencer.md
CONV_FRAME_SEQUENCER -- requirements
Module: conv_frame_sequencer

Interface
REQ-001 Parameter FILTER_SIZE, default -1, filter side length in pixels; legal range 1..IMAGE_SIZE, elaboration error otherwise.
REQ-002 Parameter IMAGE_SIZE, default -1, image side length in pixels (square frame); legal minimum 2.
REQ-003 Derived width AW = `LOG2(IMAGE_SIZE); every coordinate bus SHALL be AW bits.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begin one frame; sampled only in IDLE.
REQ-007 abort  input  1  terminate current frame.
REQ-008 in_valid  input  1  upstream pixel available.
REQ-009 in_ready  output  1  sequencer accepts pixel this cycle.
REQ-010 buf_clk_en  output  1  clock enable to pixel buffer controller/line buffers.
REQ-011 out_valid  output  1  full filter window available downstream.
REQ-012 out_ready  input  1  downstream consumes window.
REQ-013 out_x  output  AW  window top-left column; out_y  output  AW  window top-left row.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 frame_done  output  1  one-cycle pulse at normal frame completion.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; encoding implementation-defined.
REQ-017 IDLE -> RUN when start=1; x, y cleared to 0 on that edge.
REQ-018 RUN: in_ready = (out_ready | ~out_valid); combinational, no other term; 0 in all other states.
REQ-019 Accept = in_valid & in_ready; buf_clk_en SHALL equal accept exactly (combinational, same cycle).
REQ-020 On accept: x increments; at x = IMAGE_SIZE-1 x wraps to 0 and y increments.
REQ-021 On accept with x >= FILTER_SIZE-1 and y >= FILTER_SIZE-1 (pre-increment values): next cycle out_valid=1, out_x = x-(FILTER_SIZE-1), out_y = y-(FILTER_SIZE-1).
REQ-022 out_valid held with out_x/out_y stable until out_ready=1; cleared next cycle unless a new window is loaded the same cycle (new window wins, no bubble).
REQ-023 Latency: accepted pixel completing a window -> out_valid exactly 1 cycle later.
REQ-024 Accept of pixel (IMAGE_SIZE-1, IMAGE_SIZE-1): RUN -> DRAIN; x, y wrap to 0.
REQ-025 DRAIN -> DONE when out_valid=0 or (out_valid & out_ready); no pixels accepted in DRAIN.
REQ-026 DONE: frame_done=1 for exactly one cycle, then IDLE unconditionally.
REQ-027 abort=1 in RUN or DRAIN: next state IDLE, out_valid cleared, x, y cleared, no frame_done; abort has priority over every other transition; abort in IDLE/DONE ignored.
REQ-028 start asserted outside IDLE ignored; start and abort both high in IDLE: start taken.
REQ-029 FILTER_SIZE=1: every accepted pixel produces a window (out_x=x, out_y=y).
REQ-030 Windows per frame SHALL equal (IMAGE_SIZE-FILTER_SIZE+1)^2; no window duplicated or dropped under any out_ready pattern.

Reset
REQ-031 rst=1 asynchronously forces IDLE, x=y=0, out_valid=0, out_x=out_y=0, frame_done=0; busy, in_ready, buf_clk_en read 0 while rst high.
REQ-032 rst asserted mid-frame discards frame; first post-reset activity requires new start.

Verification
REQ-033 IMAGE_SIZE=4, FILTER_SIZE=3, in_valid=1, out_ready=1 constantly, start pulse -> 16 accepts, 4 windows at (0,0),(1,0),(0,1),(1,1), frame_done 1 cycle after DRAIN entry+1, busy falls after.
REQ-034 Same config, out_ready=0 for 5 cycles when first window valid -> out_valid and (0,0) held, in_ready=0, buf_clk_en=0 throughout, no accepts.
REQ-035 Random in_valid/out_ready toggling over 3 frames, IMAGE_SIZE=8, FILTER_SIZE=3 -> exactly 36 windows per frame in raster order, buf_clk_en count = 64 per frame.
REQ-036 abort mid-RUN at pixel 7 -> IDLE next cycle, out_valid=0, no frame_done; new start restarts at (0,0).
REQ-037 rst pulse asserted between clock edges during RUN -> outputs reset immediately, before next edge.
REQ-038 FILTER_SIZE=1, IMAGE_SIZE=2 -> 4 windows at (0,0),(1,0),(0,1),(1,1), each 1 cycle after its accept.
